link_tx_scheduler: RTL and testbench

LINK_TX_SCHEDULER -- requirements
Module: link_tx_scheduler

---
 rtl/link_tx_scheduler_if.sv | 46 ++++
 rtl/link_tx_scheduler.sv | 196 +++++++++++++++++++
 tb/tb_link_tx_scheduler.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/link_tx_scheduler_if.sv
// link_tx_scheduler_if
//   Groups the link-side signals of the transmit scheduler.
//   slave  : the scheduler (consumes requests/completions, drives launches).
//   master : the surrounding logic (game logic, serial senders, receiver).
//   Data side     : send_data_req, data_send_done, ack_received,
//                   received_seqNum_h -> data_send_start, data_seqNum,
//                   data_req_done, retry_cnt, link_fail.
//   Handshake side: send_ready_ACK, ack_seqNum, send_game_lost,
//                   hnd_send_done -> hnd_send_start, hnd_pid, hnd_seqNum.
//   Control       : game_active, init_seqNum.
interface link_tx_scheduler_if;
  logic       game_active;
  logic       init_seqNum;
  logic       send_data_req;
  logic       data_send_done;
  logic       ack_received;
  logic       received_seqNum_h;
  logic       send_ready_ACK;
  logic       ack_seqNum;
  logic       send_game_lost;
  logic       hnd_send_done;
  logic       data_send_start;
  logic       data_seqNum;
  logic       data_req_done;
  logic       hnd_send_start;
  logic       hnd_pid;
  logic       hnd_seqNum;
  logic [3:0] retry_cnt;
  logic       link_fail;

  modport slave (
    input  game_active, init_seqNum, send_data_req, data_send_done,
           ack_received, received_seqNum_h, send_ready_ACK, ack_seqNum,
           send_game_lost, hnd_send_done,
    output data_send_start, data_seqNum, data_req_done, hnd_send_start,
           hnd_pid, hnd_seqNum, retry_cnt, link_fail
  );

  modport master (
    output game_active, init_seqNum, send_data_req, data_send_done,
           ack_received, received_seqNum_h, send_ready_ACK, ack_seqNum,
           send_game_lost, hnd_send_done,
    input  data_send_start, data_seqNum, data_req_done, hnd_send_start,
           hnd_pid, hnd_seqNum, retry_cnt, link_fail
  );
endinterface

// File: rtl/link_tx_scheduler.sv
// link_tx_scheduler
//   Schedules outgoing packets on a serial game link. A stop-and-wait data
//   FSM sends one frame at a time with an alternating sequence bit and
//   retransmits on ACK timeout, giving up after MAX_RETRIES retransmits.
//   An independent handshake FSM sends ACK and GAME_LOST packets, with
//   GAME_LOST taking priority when both are pending.
// Ports:
//   clk   : sole clock.
//   rst_l : asynchronous reset, active high (1 = reset).
//   lnk   : link_tx_scheduler_if.slave, all request/launch/status signals.
// Parameters:
//   TIMEOUT_CYCLES : cycles spent waiting for an ACK before retransmitting.
//   MAX_RETRIES    : retransmits allowed before link_fail (at most 15).
module link_tx_scheduler #(
  parameter int TIMEOUT_CYCLES = 200,
  parameter int MAX_RETRIES    = 7
) (
  input logic                clk,
  input logic                rst_l,
  link_tx_scheduler_if.slave lnk
);

  localparam int TIMER_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]         RETRY_MAX  = 4'(MAX_RETRIES);

  typedef enum logic [1:0] {D_IDLE, D_BUSY, D_WAIT_ACK, D_FAIL} d_state_t;
  typedef enum logic       {H_IDLE, H_BUSY} h_state_t;

  d_state_t           d_state_q, d_state_d;
  h_state_t           h_state_q, h_state_d;
  logic               tx_seq_q, tx_seq_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [3:0]         retry_cnt_q, retry_cnt_d;
  logic               link_fail_q, link_fail_d;
  logic               data_send_start_q, data_send_start_d;
  logic               data_seq_num_q, data_seq_num_d;
  logic               data_req_done_q, data_req_done_d;
  logic               pend_ack_q, pend_ack_d;
  logic               pend_lost_q, pend_lost_d;
  logic               hnd_send_start_q, hnd_send_start_d;
  logic               hnd_pid_q, hnd_pid_d;
  logic               hnd_seq_num_q, hnd_seq_num_d;

  logic valid_ack;
  logic timeout;

  // The peer acknowledges a frame by returning the sequence bit it expects
  // next, i.e. the inverse of the bit we sent.
  assign valid_ack = lnk.ack_received && (lnk.received_seqNum_h != tx_seq_q);
  assign timeout   = (timer_q == TIMER_LAST);

  // Data FSM next state
  always_comb begin
    d_state_d         = d_state_q;
    tx_seq_d          = tx_seq_q;
    timer_d           = timer_q;
    retry_cnt_d       = retry_cnt_q;
    link_fail_d       = link_fail_q;
    data_send_start_d = 1'b0;
    data_req_done_d   = 1'b0;
    data_seq_num_d    = data_seq_num_q;

    if (!lnk.game_active) begin
      d_state_d   = D_IDLE;
      tx_seq_d    = lnk.init_seqNum;
      timer_d     = '0;
      retry_cnt_d = '0;
      link_fail_d = 1'b0;
    end else begin
      case (d_state_q)
        D_IDLE: begin
          if (lnk.send_data_req) begin
            data_send_start_d = 1'b1;
            data_seq_num_d    = tx_seq_q;
            d_state_d         = D_BUSY;
          end
        end
        D_BUSY: begin
          if (lnk.data_send_done) begin
            timer_d   = '0;
            d_state_d = D_WAIT_ACK;
          end
        end
        D_WAIT_ACK: begin
          // A valid ACK wins over a timeout landing on the same cycle.
          if (valid_ack) begin
            tx_seq_d        = ~tx_seq_q;
            retry_cnt_d     = '0;
            data_req_done_d = 1'b1;
            d_state_d       = D_IDLE;
          end else if (timeout) begin
            if (retry_cnt_q < RETRY_MAX) begin
              // Retransmit: data_seq_num_q still holds tx_seq_q.
              retry_cnt_d       = retry_cnt_q + 4'd1;
              data_send_start_d = 1'b1;
              d_state_d         = D_BUSY;
            end else begin
              link_fail_d = 1'b1;
              d_state_d   = D_FAIL;
            end
          end else begin
            timer_d = timer_q + TIMER_W'(1);
          end
        end
        D_FAIL: begin
          // Only a flush (game_active low) gets out of here.
        end
        default: d_state_d = D_IDLE;
      endcase
    end
  end

  // Handshake FSM next state
  always_comb begin
    h_state_d        = h_state_q;
    hnd_send_start_d = 1'b0;
    hnd_pid_d        = hnd_pid_q;
    hnd_seq_num_d    = hnd_seq_num_q;
    // Requests merge into the pending flags; a request arriving on the
    // cycle its flag is consumed re-sets it via the OR below.
    pend_ack_d       = pend_ack_q | lnk.send_ready_ACK;
    pend_lost_d      = pend_lost_q | lnk.send_game_lost;

    if (!lnk.game_active) begin
      h_state_d   = H_IDLE;
      pend_ack_d  = 1'b0;
      pend_lost_d = 1'b0;
    end else begin
      case (h_state_q)
        H_IDLE: begin
          if (pend_lost_q) begin
            hnd_send_start_d = 1'b1;
            hnd_pid_d        = 1'b0;
            pend_lost_d      = lnk.send_game_lost;
            h_state_d        = H_BUSY;
          end else if (pend_ack_q) begin
            hnd_send_start_d = 1'b1;
            hnd_pid_d        = 1'b1;
            hnd_seq_num_d    = lnk.ack_seqNum;
            pend_ack_d       = lnk.send_ready_ACK;
            h_state_d        = H_BUSY;
          end
        end
        H_BUSY: begin
          if (lnk.hnd_send_done) h_state_d = H_IDLE;
        end
        default: h_state_d = H_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst_l) begin
    if (rst_l) begin
      d_state_q         <= D_IDLE;
      h_state_q         <= H_IDLE;
      tx_seq_q          <= 1'b0;
      timer_q           <= '0;
      retry_cnt_q       <= '0;
      link_fail_q       <= 1'b0;
      data_send_start_q <= 1'b0;
      data_seq_num_q    <= 1'b0;
      data_req_done_q   <= 1'b0;
      pend_ack_q        <= 1'b0;
      pend_lost_q       <= 1'b0;
      hnd_send_start_q  <= 1'b0;
      hnd_pid_q         <= 1'b0;
      hnd_seq_num_q     <= 1'b0;
    end else begin
      d_state_q         <= d_state_d;
      h_state_q         <= h_state_d;
      tx_seq_q          <= tx_seq_d;
      timer_q           <= timer_d;
      retry_cnt_q       <= retry_cnt_d;
      link_fail_q       <= link_fail_d;
      data_send_start_q <= data_send_start_d;
      data_seq_num_q    <= data_seq_num_d;
      data_req_done_q   <= data_req_done_d;
      pend_ack_q        <= pend_ack_d;
      pend_lost_q       <= pend_lost_d;
      hnd_send_start_q  <= hnd_send_start_d;
      hnd_pid_q         <= hnd_pid_d;
      hnd_seq_num_q     <= hnd_seq_num_d;
    end
  end

  assign lnk.data_send_start = data_send_start_q;
  assign lnk.data_seqNum     = data_seq_num_q;
  assign lnk.data_req_done   = data_req_done_q;
  assign lnk.hnd_send_start  = hnd_send_start_q;
  assign lnk.hnd_pid         = hnd_pid_q;
  assign lnk.hnd_seqNum      = hnd_seq_num_q;
  assign lnk.retry_cnt       = retry_cnt_q;
  assign lnk.link_fail       = link_fail_q;

endmodule

// File: tb/tb_link_tx_scheduler.sv
// tb_link_tx_scheduler
//   Randomized bench for link_tx_scheduler. The data side is modelled per
//   frame (expected sequence bit, attempts, exact timeout instant); the
//   handshake side is modelled as a set of owed packet types plus a remote
//   sender that completes each packet after a random delay.
module tb_link_tx_scheduler;
  localparam int TIMEOUT = 200;
  localparam int MAXR    = 7;

  logic clk   = 1'b0;
  logic rst_l = 1'b0;
  always #5 clk = ~clk;

  link_tx_scheduler_if lnk();

  link_tx_scheduler #(.TIMEOUT_CYCLES(TIMEOUT), .MAX_RETRIES(MAXR)) dut (
    .clk   (clk),
    .rst_l (rst_l),
    .lnk   (lnk.slave)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int n_dstart = 0;
  int n_ddone  = 0;
  bit model_seq;
  bit d_track  = 1'b0;
  bit d_exp_seq;
  bit owed_ack, owed_lost, hnd_busy;
  bit held_pid, held_hseq;
  int hnd_wait;
  int hnd_lo   = 1;
  int hnd_hi   = 6;
  bit hnd_rand = 1'b0;
  bit hnd_log[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [10:0] outs();
    return {lnk.data_send_start, lnk.data_seqNum, lnk.data_req_done, lnk.hnd_send_start,
            lnk.hnd_pid, lnk.hnd_seqNum, lnk.retry_cnt, lnk.link_fail};
  endfunction

  // One clock: capture inputs seen by the coming edge, sample outputs at the
  // following negedge, update the models, then drive the next inputs.
  task automatic step();
    bit ra, rl, hs, hd, ga, rs;
    ra = lnk.send_ready_ACK; rl = lnk.send_game_lost; hs = lnk.ack_seqNum;
    hd = lnk.hnd_send_done;  ga = lnk.game_active;    rs = rst_l;
    @(negedge clk);
    cyc++;
    if (lnk.data_send_start) n_dstart++;
    if (lnk.data_req_done)   n_ddone++;
    if (d_track) check("data_seq_hold", lnk.data_seqNum, d_exp_seq);
    if (rs || !ga) begin
      hnd_busy = 0; owed_ack = 0; owed_lost = 0;
    end else begin
      if (hd) hnd_busy = 0;
      if (lnk.hnd_send_start) begin
        check("hnd_overlap", hnd_busy, 0);
        if (lnk.hnd_pid) begin
          check("hnd_ack_owed", owed_ack, 1);
          check("hnd_lost_priority", owed_lost, 0);
          check("hnd_ack_seq", lnk.hnd_seqNum, hs);
          owed_ack = 0;
        end else begin
          check("hnd_lost_owed", owed_lost, 1);
          owed_lost = 0;
        end
        $display("hnd packet: pid=%0d seq=%0d cycle=%0d", lnk.hnd_pid, lnk.hnd_seqNum, cyc);
        hnd_log.push_back(lnk.hnd_pid);
        hnd_busy  = 1;
        held_pid  = lnk.hnd_pid;
        held_hseq = lnk.hnd_seqNum;
        hnd_wait  = $urandom_range(hnd_lo, hnd_hi);
      end else if (hnd_busy) begin
        check("hnd_hold", {lnk.hnd_pid, lnk.hnd_seqNum}, {held_pid, held_hseq});
      end
      owed_ack  |= ra;
      owed_lost |= rl;
    end
    lnk.hnd_send_done = 1'b0;
    if (hnd_busy) begin
      if (hnd_wait == 0) lnk.hnd_send_done = 1'b1;
      else hnd_wait--;
    end
    lnk.send_ready_ACK = hnd_rand && ($urandom_range(0, 19) == 0);
    lnk.send_game_lost = hnd_rand && ($urandom_range(0, 59) == 0);
    lnk.ack_seqNum     = 1'($urandom);
  endtask

  // n cycles of waiting, optionally sprinkled with stale ACKs (seq == tx_seq).
  task automatic wait_steps(input int n, input bit stale);
    for (int i = 0; i < n; i++) begin
      if (stale && (i == 3 || $urandom_range(0, 15) == 0)) begin
        lnk.ack_received = 1'b1;
        lnk.received_seqNum_h = model_seq;
      end
      step();
      lnk.ack_received = 1'b0;
    end
  endtask

  // One frame. 'fails' timeouts happen before a valid ACK; fails > MAXR means
  // the link must fail. 'collide' puts the ACK on the timeout cycle.
  task automatic data_frame(input int fails, input bit collide, input int ack_wait);
    int s0, d0, att, w;
    bit fin;
    s0 = n_dstart; d0 = n_ddone;
    lnk.send_data_req = 1'b1;
    step();
    lnk.send_data_req = 1'b0;
    check("launch", lnk.data_send_start, 1);
    check("launch_seq", lnk.data_seqNum, model_seq);
    d_exp_seq = model_seq; d_track = 1'b1;
    att = 0; fin = 1'b0;
    while (!fin) begin
      check("retry_cnt", lnk.retry_cnt, att);
      // While the sender is busy, even a correctly numbered ACK is ignored.
      repeat ($urandom_range(0, 4)) begin
        if ($urandom_range(0, 2) == 0) begin
          lnk.ack_received = 1'b1;
          lnk.received_seqNum_h = ~model_seq;
        end
        step();
        lnk.ack_received = 1'b0;
      end
      lnk.data_send_done = 1'b1; step(); lnk.data_send_done = 1'b0;
      if (att < fails) begin
        wait_steps(TIMEOUT - 1, 1);
        check("no_early_retx", n_dstart - s0, att + 1);
        step();
        if (att < MAXR) begin
          check("retransmit", lnk.data_send_start, 1);
          att++;
        end else begin
          check("link_fail_set", lnk.link_fail, 1);
          check("fail_no_start", lnk.data_send_start, 0);
          fin = 1'b1;
        end
      end else begin
        w = collide ? TIMEOUT - 1 : ((ack_wait >= 0) ? ack_wait : $urandom_range(0, TIMEOUT - 2));
        wait_steps(w, 1);
        lnk.ack_received = 1'b1; lnk.received_seqNum_h = ~model_seq;
        step();
        lnk.ack_received = 1'b0;
        check("ack_done", lnk.data_req_done, 1);
        check("ack_no_retx", lnk.data_send_start, 0);
        check("ack_retry_clr", lnk.retry_cnt, 0);
        model_seq = ~model_seq;
        fin = 1'b1;
      end
    end
    d_track = 1'b0;
    check("frame_starts", n_dstart - s0, (fails > MAXR) ? MAXR + 1 : fails + 1);
    check("frame_dones", n_ddone - d0, (fails > MAXR) ? 0 : 1);
    $display("data frame: seq=%0d timeouts=%0d collide=%0d starts=%0d dones=%0d",
             d_exp_seq, fails, collide, n_dstart - s0, n_ddone - d0);
  endtask

  task automatic hnd_drain();
    int lim;
    lim = 0;
    while ((owed_ack || owed_lost || hnd_busy) && lim < 200) begin
      step();
      lim++;
    end
    check("hnd_drained", {owed_ack, owed_lost, hnd_busy}, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish by cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s0, d0, lim, nf;
    lnk.game_active = 0; lnk.init_seqNum = 0; lnk.send_data_req = 0;
    lnk.data_send_done = 0; lnk.ack_received = 0; lnk.received_seqNum_h = 0;
    lnk.send_ready_ACK = 0; lnk.ack_seqNum = 0; lnk.send_game_lost = 0;
    lnk.hnd_send_done = 0;
    #2 rst_l = 1'b1;
    repeat (3) step();
    check("reset_outputs", outs(), 0);
    rst_l = 1'b0;
    step();
    lnk.game_active = 1'b1; model_seq = 1'b0;
    step();

    // Directed: normal send, ACK two cycles after done.
    data_frame(0, 0, 2);
    // Directed: stale ACKs then one timeout and retransmit.
    data_frame(1, 0, -1);
    // Directed: valid ACK on the timeout cycle.
    data_frame(0, 1, -1);

    // Random frames with handshake traffic running alongside.
    hnd_rand = 1'b1;
    for (int f = 0; f < 14; f++) begin
      nf = ($urandom_range(0, 9) < 6) ? 0 : $urandom_range(1, 3);
      data_frame(nf, ($urandom_range(0, 7) == 0), -1);
      repeat ($urandom_range(0, 5)) step();
    end

    // Retries exhausted, D_FAIL is deaf, flush recovers.
    data_frame(MAXR + 1, 0, -1);
    s0 = n_dstart; d0 = n_ddone;
    lnk.send_data_req = 1'b1;
    repeat (6) begin
      lnk.data_send_done = 1'b1; lnk.ack_received = 1'b1; lnk.received_seqNum_h = ~model_seq;
      step();
    end
    lnk.send_data_req = 0; lnk.data_send_done = 0; lnk.ack_received = 0;
    step();
    check("fail_hold_starts", n_dstart - s0, 0);
    check("fail_hold_dones", n_ddone - d0, 0);
    check("fail_sticky", lnk.link_fail, 1);
    lnk.init_seqNum = 1'($urandom);
    lnk.game_active = 1'b0;
    step();
    check("flush_link_fail", lnk.link_fail, 0);
    check("flush_retry", lnk.retry_cnt, 0);
    lnk.game_active = 1'b1; model_seq = lnk.init_seqNum;
    step();
    data_frame(0, 0, -1);

    // Directed handshake arbitration and merging.
    hnd_rand = 1'b0;
    hnd_drain();
    hnd_lo = 8; hnd_hi = 8;
    hnd_log.delete();
    lnk.send_ready_ACK = 1'b1; lnk.send_game_lost = 1'b1;
    step();
    lim = 0;
    while (hnd_log.size() == 0 && lim < 10) begin step(); lim++; end
    check("arb_first_sent", hnd_log.size(), 1);
    if (hnd_log.size() > 0) check("arb_first_pid", hnd_log[0], 0);
    repeat (3) begin lnk.send_ready_ACK = 1'b1; step(); end
    hnd_drain();
    check("arb_total_packets", hnd_log.size(), 2);
    if (hnd_log.size() > 1) check("arb_second_pid", hnd_log[1], 1);
    hnd_lo = 1; hnd_hi = 6;

    // Reset in the middle of a retransmitted frame.
    lnk.init_seqNum = 1'b1; lnk.game_active = 1'b0; step();
    lnk.game_active = 1'b1; model_seq = 1'b1; step();
    lnk.send_data_req = 1'b1; step(); lnk.send_data_req = 1'b0;
    check("rst_pre_launch", lnk.data_send_start, 1);
    lnk.data_send_done = 1'b1; step(); lnk.data_send_done = 1'b0;
    wait_steps(TIMEOUT - 1, 0);
    step();
    check("rst_pre_retx", lnk.data_send_start, 1);
    check("rst_pre_retry", lnk.retry_cnt, 1);
    step();
    rst_l = 1'b1;
    #1;
    check("rst_async_outputs", outs(), 0);
    s0 = n_dstart; d0 = n_ddone;
    repeat (3) step();
    rst_l = 1'b0;
    repeat (4) begin
      lnk.data_send_done = 1'b1; lnk.ack_received = 1'b1; lnk.received_seqNum_h = 1'b1;
      step();
    end
    lnk.data_send_done = 0; lnk.ack_received = 0;
    step();
    check("rst_no_start", n_dstart - s0, 0);
    check("rst_no_done", n_ddone - d0, 0);
    model_seq = 1'b0;
    data_frame(0, 0, -1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
